// File: rtl/reg_move_pkg.sv
// Shared types for the register-move sequencer: register indices, FSM states, decoded instruction fields.
package reg_move_pkg;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_B  = 3'd1,
    REG_C  = 3'd2,
    REG_D  = 3'd3,
    REG_M1 = 3'd4,
    REG_M2 = 3'd5,
    REG_X  = 3'd6,
    REG_Y  = 3'd7
  } reg_idx_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    LOAD    = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    KIND_MOV8  = 2'd0,
    KIND_SETAB = 2'd1,
    KIND_OTHER = 2'd2
  } instr_kind_e;

  localparam logic [1:0] OP_MOV8  = 2'b00;
  localparam logic [1:0] OP_SETAB = 2'b01;

  typedef struct packed {
    instr_kind_e kind;
    reg_idx_e    src;
    reg_idx_e    dst;
    logic [7:0]  imm;
    logic        is_clear;
  } dec_t;

  function automatic logic [7:0] sext5to8(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

  function automatic logic [7:0] onehot8(input reg_idx_e r);
    return 8'b0000_0001 << r;
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

endpackage

// File: rtl/reg_move_decode.sv
// Combinational instruction decoder: instr byte -> kind, source, destination, immediate, clear flag.
module reg_move_decode
  import reg_move_pkg::*;
(
  input  logic [7:0] instr,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.kind     = KIND_OTHER;
    dec.src      = reg_idx_e'(instr[2:0]);
    dec.dst      = reg_idx_e'(instr[5:3]);
    dec.imm      = 8'h00;
    dec.is_clear = 1'b0;
    case (instr[7:6])
      OP_MOV8: begin
        dec.kind = KIND_MOV8;
        // Self-move is repurposed as a clear: the sequencer drives 0x00 instead of the register.
        dec.is_clear = (instr[5:3] == instr[2:0]);
      end
      OP_SETAB: begin
        dec.kind = KIND_SETAB;
        dec.src  = REG_A;
        dec.dst  = instr[5] ? REG_B : REG_A;
        dec.imm  = sext5to8(instr[4:0]);
      end
      default: dec.kind = KIND_OTHER;
    endcase
  end

endmodule

// File: rtl/reg_move_sequencer.sv
// Sequences MOV8/SETAB bytes into timed one-hot sel/ld pulses (or an immediate bus drive) for the register file.
// Build option REG_MOVE_ILLEGAL_TRAP_EN: 1x opcodes trap (sticky illegal, busy held) instead of acting as NOPs.
module reg_move_sequencer
  import reg_move_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned LOAD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic       busy,
  output logic       done,
  output logic [7:0] sel,
  output logic [7:0] ld,
  output logic       imm_drive,
  output logic [7:0] imm_data,
  output logic       illegal
);

  seq_state_e state;
  logic [2:0] cnt;
  logic [7:0] instr_q;
  logic [7:0] dec_instr;
  dec_t       dec;
  logic       uses_imm;
  logic       trapped;
  logic       accept;

  // In IDLE decode the live byte so the bus source is valid on the first cycle after accept.
  assign dec_instr = (state == IDLE) ? instr : instr_q;

  reg_move_decode u_decode (
    .instr (dec_instr),
    .dec   (dec)
  );

  assign uses_imm = (dec.kind == KIND_SETAB) || dec.is_clear;
  assign accept   = start && !trapped && (state == IDLE);

`ifdef REG_MOVE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trapped <= 1'b0;
    end else if (accept && (dec.kind == KIND_OTHER)) begin
      trapped <= 1'b1;
    end
  end
  assign illegal = trapped;
`else
  assign trapped = 1'b0;
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      instr_q   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel       <= 8'h00;
      ld        <= 8'h00;
      imm_drive <= 1'b0;
      imm_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            instr_q <= instr;
            busy    <= 1'b1;
            if (dec.kind == KIND_OTHER) begin
`ifndef REG_MOVE_ILLEGAL_TRAP_EN
              state <= DONE;
              done  <= 1'b1;
`endif
            end else begin
              state <= SETTLE;
              cnt   <= 3'd1;
              if (uses_imm) begin
                imm_drive <= 1'b1;
                imm_data  <= dec.imm;
              end else begin
                sel <= onehot8(dec.src);
              end
            end
          end
        end
        SETTLE: begin
          if (cnt >= 3'(SETTLE_CYCLES)) begin
            state <= LOAD;
            cnt   <= 3'd1;
            ld    <= onehot8(dec.dst);
          end else begin
            cnt <= sat_inc3(cnt);
          end
        end
        LOAD: begin
          if (cnt >= 3'(LOAD_CYCLES)) begin
            state <= RELEASE;
            cnt   <= 3'd1;
            ld    <= 8'h00;
          end else begin
            cnt <= sat_inc3(cnt);
          end
        end
        RELEASE: begin
          // First cycle keeps the source on the bus for hold time; second cycle leaves the bus quiet.
          if (cnt == 3'd1) begin
            cnt       <= 3'd2;
            sel       <= 8'h00;
            imm_drive <= 1'b0;
            imm_data  <= 8'h00;
          end else begin
            state <= DONE;
            cnt   <= 3'd0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ld_has_source: assert property (@(posedge clk) disable iff (reset)
    (ld != 8'h00) |-> ((sel != 8'h00) || imm_drive));
  a_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(sel) && $onehot0(ld));
  a_sel_imm_excl: assert property (@(posedge clk) disable iff (reset)
    !(imm_drive && (sel != 8'h00)));
  a_imm_quiet: assert property (@(posedge clk) disable iff (reset)
    !imm_drive |-> (imm_data == 8'h00));

endmodule

// File: tb/tb_reg_move_sequencer.sv
// Self-checking bench for reg_move_sequencer: fixed vector table, hand-written corner sequences, random model check.
module tb_reg_move_sequencer;

  localparam int S = 1;
  localparam int L = 2;
  localparam int MOVE_DONE_K = S + L + 3;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] ld;
    logic       imm;
    logic [7:0] data;
    logic       done;
    logic       busy;
  } out_t;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] sel_v;
    logic [7:0] ld_v;
    logic       imm_v;
    logic [7:0] data_v;
    int         done_k;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       busy;
  logic       done;
  logic [7:0] sel;
  logic [7:0] ld;
  logic       imm_drive;
  logic [7:0] imm_data;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  reg_move_sequencer #(.SETTLE_CYCLES(S), .LOAD_CYCLES(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .instr     (instr),
    .busy      (busy),
    .done      (done),
    .sel       (sel),
    .ld        (ld),
    .imm_drive (imm_drive),
    .imm_data  (imm_data),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs k cycles after the accept cycle, from the documented timeline.
  function automatic out_t expect_at(input logic [7:0] sel_v, input logic [7:0] ld_v,
                                     input logic imm_v, input logic [7:0] data_v,
                                     input int done_k, input int k);
    out_t e;
    bit   mov;
    e      = '0;
    mov    = (done_k > 1);
    e.busy = (k >= 1) && (k <= done_k);
    e.done = (k == done_k);
    if (mov && k >= 1 && k <= S + L + 1) begin
      if (imm_v) begin
        e.imm  = 1'b1;
        e.data = data_v;
      end else begin
        e.sel = sel_v;
      end
    end
    if (mov && k >= S + 1 && k <= S + L) e.ld = ld_v;
    return e;
  endfunction

  // Reference decode written directly from the instruction-format rules.
  task automatic model(input logic [7:0] ins, output logic [7:0] sel_v, output logic [7:0] ld_v,
                       output logic imm_v, output logic [7:0] data_v, output int done_k);
    int op, d, s, v;
    op = int'(ins) / 64;
    d  = (int'(ins) / 8) % 8;
    s  = int'(ins) % 8;
    sel_v = 8'h00; ld_v = 8'h00; imm_v = 1'b0; data_v = 8'h00; done_k = 1;
    if (op == 0) begin
      done_k = MOVE_DONE_K;
      ld_v   = 8'(1 << d);
      if (d == s) imm_v = 1'b1;
      else sel_v = 8'(1 << s);
    end else if (op == 1) begin
      done_k = MOVE_DONE_K;
      v      = int'(ins) % 32;
      ld_v   = ((int'(ins) / 32) % 2 == 1) ? 8'h02 : 8'h01;
      imm_v  = 1'b1;
      data_v = (v >= 16) ? 8'(v + 224) : 8'(v);
    end
  endtask

  task automatic check_cycle(input string tag, input int k, input out_t e);
    chk($sformatf("%s k%0d sel", tag, k), 32'(sel), 32'(e.sel));
    chk($sformatf("%s k%0d ld", tag, k), 32'(ld), 32'(e.ld));
    chk($sformatf("%s k%0d imm_drive", tag, k), 32'(imm_drive), 32'(e.imm));
    chk($sformatf("%s k%0d imm_data", tag, k), 32'(imm_data), 32'(e.data));
    chk($sformatf("%s k%0d done", tag, k), 32'(done), 32'(e.done));
    chk($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'(e.busy));
    chk($sformatf("%s k%0d illegal", tag, k), 32'(illegal), 32'(1'b0));
  endtask

  task automatic run_instr(input string tag, input logic [7:0] ins, input logic [7:0] sel_v,
                           input logic [7:0] ld_v, input logic imm_v, input logic [7:0] data_v,
                           input int done_k, input bit hold);
    start = 1'b1;
    instr = ins;
    for (int k = 1; k <= done_k + 1; k++) begin
      tick();
      if (hold) instr = 8'($urandom);
      else start = 1'b0;
      check_cycle(tag, k, expect_at(sel_v, ld_v, imm_v, data_v, done_k, k));
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] m_sel, m_ld, m_data, ins;
    logic       m_imm;
    int         m_done, gap;

    vecs.push_back('{8'h0A, 8'h04, 8'h02, 1'b0, 8'h00, 6});
    vecs.push_back('{8'h50, 8'h00, 8'h01, 1'b1, 8'hF0, 6});
    vecs.push_back('{8'h1B, 8'h00, 8'h08, 1'b1, 8'h00, 6});
    vecs.push_back('{8'h6F, 8'h00, 8'h02, 1'b1, 8'h0F, 6});
    vecs.push_back('{8'h30, 8'h01, 8'h40, 1'b0, 8'h00, 6});
    vecs.push_back('{8'h3F, 8'h00, 8'h80, 1'b1, 8'h00, 6});
    vecs.push_back('{8'h07, 8'h80, 8'h01, 1'b0, 8'h00, 6});
`ifndef REG_MOVE_ILLEGAL_TRAP_EN
    vecs.push_back('{8'h80, 8'h00, 8'h00, 1'b0, 8'h00, 1});
    vecs.push_back('{8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1});
`endif

    reset = 1'b1;
    start = 1'b0;
    instr = 8'h00;
    tick();
    tick();
    check_cycle("reset", 0, '0);
    reset = 1'b0;
    tick();

    foreach (vecs[i])
      run_instr($sformatf("vec%0d_%02h", i, vecs[i].instr), vecs[i].instr, vecs[i].sel_v,
                vecs[i].ld_v, vecs[i].imm_v, vecs[i].data_v, vecs[i].done_k, 1'b0);

    // Async reset during LOAD of X<-A must kill the move without any further ld.
    start = 1'b1;
    instr = 8'h30;
    tick();
    start = 1'b0;
    check_cycle("rst_load", 1, expect_at(8'h01, 8'h40, 1'b0, 8'h00, MOVE_DONE_K, 1));
    tick();
    check_cycle("rst_load", 2, expect_at(8'h01, 8'h40, 1'b0, 8'h00, MOVE_DONE_K, 2));
    #2;
    reset = 1'b1;
    #1;
    check_cycle("rst_async", 0, '0);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_cycle("rst_after", k, '0);
    end
    run_instr("rst_then_mov", 8'h0A, 8'h04, 8'h02, 1'b0, 8'h00, MOVE_DONE_K, 1'b0);

    // Start held with a changing instr byte: only the accepted byte runs, next accept after done.
    run_instr("held_start", 8'h0A, 8'h04, 8'h02, 1'b0, 8'h00, MOVE_DONE_K, 1'b1);
    run_instr("held_next", 8'h50, 8'h00, 8'h01, 1'b1, 8'hF0, MOVE_DONE_K, 1'b0);

    for (int n = 0; n < 40; n++) begin
`ifdef REG_MOVE_ILLEGAL_TRAP_EN
      ins = 8'($urandom_range(0, 127));
`else
      ins = 8'($urandom_range(0, 255));
`endif
      model(ins, m_sel, m_ld, m_imm, m_data, m_done);
      run_instr($sformatf("rnd%0d_%02h", n, ins), ins, m_sel, m_ld, m_imm, m_data, m_done, 1'($urandom_range(0, 1)));
      start = 1'b0;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        check_cycle("gap", g, '0);
      end
    end

`ifdef REG_MOVE_ILLEGAL_TRAP_EN
    start = 1'b1;
    instr = 8'h80;
    tick();
    instr = 8'h0A;
    chk("trap illegal", 32'(illegal), 32'(1'b1));
    chk("trap busy", 32'(busy), 32'(1'b1));
    chk("trap done", 32'(done), 32'(1'b0));
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk($sformatf("trap k%0d illegal", k), 32'(illegal), 32'(1'b1));
      chk($sformatf("trap k%0d busy", k), 32'(busy), 32'(1'b1));
      chk($sformatf("trap k%0d done", k), 32'(done), 32'(1'b0));
      chk($sformatf("trap k%0d sel", k), 32'(sel), 32'(8'h00));
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("trap cleared", 32'(illegal), 32'(1'b0));
    tick();
    run_instr("post_trap", 8'h0A, 8'h04, 8'h02, 1'b0, 8'h00, MOVE_DONE_K, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
